// File: rtl/intmult_pkg.sv
// Shared types and helpers for the integer multiplier family.
package intmult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Widest operand the helper functions are sized for.
  localparam int MAX_W = 64;

  function automatic int num_steps(input int width, input int step);
    return width / step;
  endfunction

  // Clamp value for a saturated result, LSB-aligned in a MAX_W-bit word.
  function automatic logic [MAX_W-1:0] sat_limits(input int width, input logic sgn,
                                                  input logic neg);
    logic [MAX_W-1:0] one;
    one = MAX_W'(1);
    if (!sgn) begin
      return (one << width) - one;
    end
    if (neg) begin
      return one << (width - 1);
    end
    return (one << (width - 1)) - one;
  endfunction

  // True when a 2*width-bit product does not fit in width bits for the given mode.
  function automatic logic ovf_check(input logic [2*MAX_W-1:0] p, input int width,
                                     input logic sgn);
    logic ovf;
    logic ref_bit;
    ovf     = 1'b0;
    ref_bit = 1'b0;
    for (int i = 0; i < 2 * MAX_W; i++) begin
      if (i == width - 1) begin
        ref_bit = p[i];
      end
    end
    for (int i = 0; i < 2 * MAX_W; i++) begin
      if (i >= width && i < 2 * width) begin
        if (sgn) begin
          ovf = ovf | (p[i] != ref_bit);
        end else begin
          ovf = ovf | p[i];
        end
      end
    end
    return ovf;
  endfunction

endpackage

// File: rtl/intmult_step.sv
// Combinational partial-product generator: multiplicand times STEP multiplier bits.
module intmult_step
  import intmult_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int STEP  = 1
) (
  input  logic [WIDTH-1:0]      mag_a,
  input  logic [STEP-1:0]       bits,
  output logic [WIDTH+STEP-1:0] pp
);

  localparam int PW = WIDTH + STEP;

  logic [PW-1:0] term [STEP];

  genvar gi;
  for (gi = 0; gi < STEP; gi++) begin : g_term
    assign term[gi] = bits[gi] ? (PW'(mag_a) << gi) : '0;
  end

  always_comb begin
    pp = '0;
    for (int i = 0; i < STEP; i++) begin
      pp = pp + term[i];
    end
  end

endmodule

// File: rtl/intmult_seq.sv
// Iterative shift-add signed/unsigned multiplier with valid/ready handshakes.
// Define INTMULT_SAT_EN to clamp Y on overflow.
module intmult_seq
  import intmult_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int STEP  = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic               is_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   Y,
  output logic [2*WIDTH-1:0] P,
  output logic               overflow
);

  localparam int N     = num_steps(WIDTH, STEP);
  localparam int CNT_W = $clog2(N + 1);
  localparam int PW    = 2 * WIDTH;

  if (WIDTH < 2 || STEP < 1 || (WIDTH % STEP) != 0 || WIDTH > MAX_W) begin : g_bad_cfg
    $error("intmult_seq: WIDTH must be >= 2, <= MAX_W and a multiple of STEP");
  end

  state_t state_reg, state_next;

  logic [CNT_W-1:0]      cnt_reg;
  logic [WIDTH-1:0]      mag_a_reg, mag_b_reg;
  logic                  neg_reg, sgn_reg;
  logic [PW-1:0]         acc_reg, p_reg;
  logic [WIDTH-1:0]      y_reg;
  logic                  ovf_reg;

  logic                  accept, step_en, finish;
  logic [WIDTH+STEP-1:0] pp;
  logic [PW-1:0]         prod;
  logic                  prod_ovf;
  logic [WIDTH-1:0]      y_next;

  // The most negative operand negates to itself, which reads correctly as unsigned 2^(W-1).
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
    return (sgn && v[WIDTH-1]) ? -v : v;
  endfunction

  intmult_step #(
    .WIDTH(WIDTH),
    .STEP (STEP)
  ) u_step (
    .mag_a(mag_a_reg),
    .bits (mag_b_reg[STEP-1:0]),
    .pp   (pp)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // BUSY spends N cycles accumulating, then one more applying sign and overflow.
  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    accept     = 1'b0;
    step_en    = 1'b0;
    finish     = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept     = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (cnt_reg == CNT_W'(N)) begin
          finish     = 1'b1;
          state_next = DONE;
        end else begin
          step_en = 1'b1;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    prod     = neg_reg ? -acc_reg : acc_reg;
    prod_ovf = ovf_check((2 * MAX_W)'(prod), WIDTH, sgn_reg);
  end

`ifdef INTMULT_SAT_EN
  logic [MAX_W-1:0] sat_full;
  always_comb begin
    sat_full = sat_limits(WIDTH, sgn_reg, neg_reg);
    y_next   = prod_ovf ? sat_full[WIDTH-1:0] : prod[WIDTH-1:0];
  end
`else
  always_comb begin
    y_next = prod[WIDTH-1:0];
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg   <= '0;
      mag_a_reg <= '0;
      mag_b_reg <= '0;
      neg_reg   <= 1'b0;
      sgn_reg   <= 1'b0;
      acc_reg   <= '0;
      p_reg     <= '0;
      y_reg     <= '0;
      ovf_reg   <= 1'b0;
    end else begin
      if (accept) begin
        mag_a_reg <= magnitude(A, is_signed);
        mag_b_reg <= magnitude(B, is_signed);
        neg_reg   <= is_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
        sgn_reg   <= is_signed;
        acc_reg   <= '0;
        cnt_reg   <= '0;
      end
      if (step_en) begin
        acc_reg   <= acc_reg + (PW'(pp) << (STEP * cnt_reg));
        mag_b_reg <= mag_b_reg >> STEP;
        cnt_reg   <= cnt_reg + CNT_W'(1);
      end
      // Result registers only load on completion, so they hold under backpressure.
      if (finish) begin
        p_reg   <= prod;
        y_reg   <= y_next;
        ovf_reg <= prod_ovf;
      end
    end
  end

  assign Y        = y_reg;
  assign P        = p_reg;
  assign overflow = ovf_reg;

endmodule

// File: tb/tb_intmult_seq.sv
// Directed-vector and randomised bench for intmult_seq at WIDTH=8 with STEP=1 and STEP=4.
module tb_intmult_seq;

`ifdef INTMULT_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        sgn;
    logic [15:0] p;
    logic        ovf;
  } vec_t;

  logic        clk, rst_n;
  logic        in_valid  [2];
  logic        in_ready  [2];
  logic        is_signed [2];
  logic        out_valid [2];
  logic        out_ready [2];
  logic        ovf_o     [2];
  logic [7:0]  a_i       [2];
  logic [7:0]  b_i       [2];
  logic [7:0]  y_o       [2];
  logic [15:0] p_o       [2];

  int checks = 0;
  int errors = 0;

  intmult_seq #(.WIDTH(8), .STEP(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .A(a_i[0]), .B(b_i[0]), .is_signed(is_signed[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .Y(y_o[0]), .P(p_o[0]), .overflow(ovf_o[0])
  );

  intmult_seq #(.WIDTH(8), .STEP(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .A(a_i[1]), .B(b_i[1]), .is_signed(is_signed[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .Y(y_o[1]), .P(p_o[1]), .overflow(ovf_o[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] model_y(input logic [15:0] p, input logic ovf, input logic sgn);
    logic [7:0] sat;
    sat = sgn ? (p[15] ? 8'h80 : 8'h7F) : 8'hFF;
    if (SAT && ovf) return sat;
    return p[7:0];
  endfunction

  function automatic logic [15:0] model_p(input logic [7:0] a, input logic [7:0] b, input logic sgn);
    logic signed [15:0] sa, sb;
    if (sgn) begin
      sa = {{8{a[7]}}, a};
      sb = {{8{b[7]}}, b};
      return sa * sb;
    end
    return {8'h00, a} * {8'h00, b};
  endfunction

  function automatic logic model_ovf(input logic [15:0] p, input logic sgn);
    if (sgn) return !(p[15:7] == 9'h000 || p[15:7] == 9'h1FF);
    return p[15:8] != 8'h00;
  endfunction

  // One transaction; operands and mode are scrambled right after acceptance.
  task automatic txn(input int w, input logic [7:0] a, input logic [7:0] b, input logic sgn,
                     input logic hold, output logic [15:0] p, output logic [7:0] y,
                     output logic ovf, output int lat);
    @(negedge clk);
    check("in_ready_idle", 32'(in_ready[w]), 32'd1);
    a_i[w] = a; b_i[w] = b; is_signed[w] = sgn; in_valid[w] = 1'b1;
    @(posedge clk); #1;
    in_valid[w] = 1'b0; a_i[w] = ~a; b_i[w] = b ^ 8'h5A; is_signed[w] = ~sgn;
    lat = 0;
    while (!out_valid[w] && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("out_valid_seen", 32'(out_valid[w]), 32'd1);
    p = p_o[w]; y = y_o[w]; ovf = ovf_o[w];
    if (!hold) begin
      out_ready[w] = 1'b1;
      @(posedge clk); #1;
      out_ready[w] = 1'b0;
      check("out_valid_drop", 32'(out_valid[w]), 32'd0);
      check("in_ready_back", 32'(in_ready[w]), 32'd1);
    end
  endtask

  initial begin
    vec_t        vecs [16];
    logic [15:0] got_p, exp_p;
    logic [7:0]  got_y, ra, rb;
    logic        got_ovf, exp_ovf, rs;
    int          lat;

    vecs[0]  = '{8'd15,  8'd17,  1'b0, 16'h00FF, 1'b0};
    vecs[1]  = '{8'd16,  8'd16,  1'b0, 16'h0100, 1'b1};
    vecs[2]  = '{8'hFD,  8'd5,   1'b1, 16'hFFF1, 1'b0};
    vecs[3]  = '{8'h80,  8'hFF,  1'b1, 16'h0080, 1'b1};
    vecs[4]  = '{8'h00,  8'hFF,  1'b0, 16'h0000, 1'b0};
    vecs[5]  = '{8'h00,  8'h80,  1'b1, 16'h0000, 1'b0};
    vecs[6]  = '{8'hFF,  8'hFF,  1'b0, 16'hFE01, 1'b1};
    vecs[7]  = '{8'hFF,  8'hFF,  1'b1, 16'h0001, 1'b0};
    vecs[8]  = '{8'h80,  8'h01,  1'b1, 16'hFF80, 1'b0};
    vecs[9]  = '{8'h7F,  8'h7F,  1'b1, 16'h3F01, 1'b1};
    vecs[10] = '{8'h80,  8'h80,  1'b1, 16'h4000, 1'b1};
    vecs[11] = '{8'd7,   8'd9,   1'b0, 16'h003F, 1'b0};
    vecs[12] = '{8'h40,  8'h02,  1'b1, 16'h0080, 1'b1};
    vecs[13] = '{8'hC0,  8'h02,  1'b1, 16'hFF80, 1'b0};
    vecs[14] = '{8'h01,  8'hFF,  1'b0, 16'h00FF, 1'b0};
    vecs[15] = '{8'hFF,  8'h80,  1'b1, 16'h0080, 1'b1};

    for (int w = 0; w < 2; w++) begin
      in_valid[w] = 1'b0; is_signed[w] = 1'b0; out_ready[w] = 1'b0;
      a_i[w] = 8'h00; b_i[w] = 8'h00;
    end
    rst_n = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready[0]), 32'd1);
    check("rst_out_valid", 32'(out_valid[0]), 32'd0);
    check("rst_y", 32'(y_o[0]), 32'd0);
    check("rst_p", 32'(p_o[0]), 32'd0);
    check("rst_ovf", 32'(ovf_o[0]), 32'd0);
    check("rst_in_ready4", 32'(in_ready[1]), 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // Directed table on both step sizes.
    for (int w = 0; w < 2; w++) begin
      for (int i = 0; i < 16; i++) begin
        txn(w, vecs[i].a, vecs[i].b, vecs[i].sgn, 1'b0, got_p, got_y, got_ovf, lat);
        $display("vec w=%0d #%0d A=%02h B=%02h s=%0d -> P=%04h Y=%02h ovf=%0d lat=%0d",
                 w, i, vecs[i].a, vecs[i].b, vecs[i].sgn, got_p, got_y, got_ovf, lat);
        check("vec_p", 32'(got_p), 32'(vecs[i].p));
        check("vec_y", 32'(got_y), 32'(model_y(vecs[i].p, vecs[i].ovf, vecs[i].sgn)));
        check("vec_ovf", 32'(got_ovf), 32'(vecs[i].ovf));
        check("vec_latency", 32'(lat), (w == 0) ? 32'd9 : 32'd3);
      end
    end

    // Backpressure: outputs frozen, new requests ignored.
    txn(0, 8'd15, 8'd17, 1'b0, 1'b1, got_p, got_y, got_ovf, lat);
    $display("bp start P=%04h Y=%02h ovf=%0d lat=%0d", got_p, got_y, got_ovf, lat);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      in_valid[0] = 1'b1; a_i[0] = 8'h33; b_i[0] = 8'h44;
      @(posedge clk); #1;
      in_valid[0] = 1'b0;
      check("bp_out_valid", 32'(out_valid[0]), 32'd1);
      check("bp_in_ready", 32'(in_ready[0]), 32'd0);
      check("bp_p", 32'(p_o[0]), 32'h00FF);
      check("bp_y", 32'(y_o[0]), 32'hFF);
      check("bp_ovf", 32'(ovf_o[0]), 32'd0);
    end
    out_ready[0] = 1'b1;
    @(posedge clk); #1;
    out_ready[0] = 1'b0;
    check("bp_release_valid", 32'(out_valid[0]), 32'd0);
    check("bp_release_ready", 32'(in_ready[0]), 32'd1);
    $display("bp released out_valid=%0d in_ready=%0d", out_valid[0], in_ready[0]);

    // Reset in the middle of an operation.
    @(negedge clk);
    a_i[0] = 8'hAA; b_i[0] = 8'h55; is_signed[0] = 1'b0; in_valid[0] = 1'b1;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid[0]), 32'd0);
    check("midrst_in_ready", 32'(in_ready[0]), 32'd1);
    check("midrst_p", 32'(p_o[0]), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    txn(0, 8'd7, 8'd9, 1'b0, 1'b0, got_p, got_y, got_ovf, lat);
    $display("after reset 7*9 -> P=%04h Y=%02h ovf=%0d lat=%0d", got_p, got_y, got_ovf, lat);
    check("postrst_p", 32'(got_p), 32'd63);
    check("postrst_y", 32'(got_y), 32'd63);
    check("postrst_ovf", 32'(got_ovf), 32'd0);

    // Random vectors against the reference model.
    for (int w = 0; w < 2; w++) begin
      for (int i = 0; i < 1000; i++) begin
        ra = 8'($urandom_range(0, 255));
        rb = 8'($urandom_range(0, 255));
        rs = 1'($urandom_range(0, 1));
        exp_p = model_p(ra, rb, rs);
        exp_ovf = model_ovf(exp_p, rs);
        txn(w, ra, rb, rs, 1'b0, got_p, got_y, got_ovf, lat);
        $display("rand w=%0d #%0d A=%02h B=%02h s=%0d -> P=%04h exp %04h", w, i, ra, rb, rs,
                 got_p, exp_p);
        check("rand_p", 32'(got_p), 32'(exp_p));
        check("rand_y", 32'(got_y), 32'(model_y(exp_p, exp_ovf, rs)));
        check("rand_ovf", 32'(got_ovf), 32'(exp_ovf));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
